msrh_ftq_mp: RTL and testbench
==============================

# msrh_ftq_mp

Multi-port Fetch Target Queue: the next-generation, parametrised FTQ between dispatch, the branch units and the frontend predictor-update path. It records every dispatched branch individually (up to ENQ_WIDTH per cycle), absorbs resolutions from UPD_PORTS branch units, and kills younger entries on a mispredict. It then retires entries strictly in program order to the frontend over a valid/ready handshake.

## Interface
- DEPTH, 16: entry count; power of two, ≥ 2·ENQ_WIDTH
- ENQ_WIDTH, 2: branches enqueued per cycle
- UPD_PORTS, 2: branch resolution ports
- BRTAG_W, 4: branch tag width; tags are unique among live entries
- VADDR_W, 39: virtual address width
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_enq_valid  in  ENQ_WIDTH  per-lane enqueue request
- i_enq  in  ENQ_WIDTH×$bits(ftq_mp_enq_t)  per lane: cmt_id, grp_id, brtag, pc_vaddr, is_call, is_ret, is_rvc
- o_enq_ready  out  1  high when free slots ≥ ENQ_WIDTH
- i_upd_valid  in  UPD_PORTS  resolution strobe
- i_upd  in  UPD_PORTS×$bits(ftq_mp_upd_t)  brtag, is_cond, taken, mispredict, target_vaddr
- i_flush  in  1  commit flush
- o_deq_valid  out  1  head entry valid and done
- i_deq_ready  in  1  frontend accepts head
- o_deq  out  $bits(ftq_mp_deq_t)  head payload, including the dead bit
- o_empty  out  1  no valid entries
- o_count  out  $clog2(DEPTH+1)  valid entry count

## Operation
- Entry state: valid, done, dead, plus payload. Head/tail pointers are $clog2(DEPTH)+1 bits, with the MSB as the wrap bit.
- Enqueue fires when (|i_enq_valid) & o_enq_ready.
  - Valid lanes need not be contiguous. They are packed in ascending lane order into tail, tail+1, …
  - Tail advances by popcount(i_enq_valid).
  - Lanes asserted while o_enq_ready=0 are dropped. Dispatch must hold them.
- Update: an i_upd_valid port matches the valid entry whose brtag equals its brtag.
  - On a match, set done=1 and capture is_cond, taken, mispredict and target_vaddr.
  - An update with no matching entry is ignored.
  - If two ports match the same entry, the lowest-index port wins.
- Mispredict kill: an update with mispredict=1 sets done=1 and dead=1 on every valid entry younger than the matched entry, where age = (ptr − head) mod DEPTH.
  - Entries enqueued in the same cycle are younger, so they are written with done=dead=1.
  - The mispredicting entry itself keeps dead=0.
  - If several ports mispredict in the same cycle, the oldest matched entry defines the kill boundary.
- Dequeue: o_deq_valid = head.valid & head.done. A transfer occurs on o_deq_valid & i_deq_ready; head is cleared and advances by 1.
- Dead entries are still dequeued, with dead=1, so pointers stay in order. The frontend ignores them.
- i_flush clears all valid bits, sets head = tail = 0, and wins over enqueue, update and dequeue in the same cycle.
- o_count = tail − head (wrap-aware). o_empty = (o_count == 0).
- Reset state: all valid=0, head = tail = 0, o_deq_valid=0, o_enq_ready=1, o_empty=1, o_count=0.

## Timing
- Enqueue to visible entry: 1 cycle. Update to done: 1 cycle, so o_deq_valid rises no earlier than the cycle after the update.
- All outputs derive from registered state only. There is no combinational path from i_upd, i_enq or i_flush to o_deq_*.
- o_enq_ready is computed from the registered count. A same-cycle dequeue does not free a slot for that cycle's enqueue.
- Full (count = DEPTH) means o_enq_ready=0. Empty means o_deq_valid=0.
- An update that hits the head in the same cycle as a dequeue of a different head is applied normally. The head being dequeued cannot match, because it is already done.
- Wrap-around is transparent. Full and empty are distinguished by the MSB of the pointers.
- Reset asserted mid-operation discards all entries at the next edge. No output is sampled as valid in the cycle after reset.

## Structure
- ftq_mp_enq_t, ftq_mp_upd_t, ftq_mp_deq_t and the entry struct ftq_mp_entry_t go in msrh_pkg, next to ftq_entry_t.
- One sub-module, msrh_ftq_mp_lane_pack: prefix popcount over i_enq_valid, producing a per-lane slot offset and the total enqueue count.
- Age comparison and kill-mask generation stay in the top level, in one always_comb over entries.

## Test plan
- Reset, then enqueue lanes 0b11 with brtags 1 and 2 → o_count=2 next cycle. Update tag 1 (taken, target 0x8000_0100) → o_deq_valid=1 the next cycle with target 0x8000_0100 and dead=0.
- Enqueue with i_enq_valid=0b10 only → entry written at tail (lane 1 packed into slot 0) and o_count=1.
- Fill 16 entries → o_enq_ready=0. Dequeue one → o_enq_ready rises only when count ≤ 14. Run 40 enqueue/dequeue pairs → pointers wrap with in-order tags.
- Entries with tags 3, 4, 5, 6, then a mispredict on tag 4 while tag 7 is enqueued in the same cycle → tags 5, 6 and 7 dequeue with dead=1, and tag 4 dequeues with mispredict=1 and dead=0.
- Both ports update tag 5 in the same cycle with different targets → port 0's target is observed. An update to an absent tag 9 → no state change.
- i_flush asserted together with an enqueue and an update → next cycle o_empty=1, o_count=0, o_deq_valid=0. Reset mid-stream gives the same result.

Source files
------------

// File: rtl/msrh_pkg.sv
// Shared types for the FTQ family: the legacy single-port entry and the
// multi-port FTQ enqueue / update / dequeue / storage records.
package msrh_pkg;

    localparam int VADDR_W  = 39;
    localparam int BRTAG_W  = 4;
    localparam int CMT_ID_W = 6;
    localparam int GRP_ID_W = 5;

    // Single-port FTQ entry used by the existing frontend update path
    typedef struct packed {
        logic                valid;
        logic [CMT_ID_W-1:0] cmt_id;
        logic [GRP_ID_W-1:0] grp_id;
        logic [VADDR_W-1:0]  pc_vaddr;
        logic [VADDR_W-1:0]  target_vaddr;
        logic                taken;
        logic                done;
    } ftq_entry_t;

    // Per-lane dispatch record
    typedef struct packed {
        logic [CMT_ID_W-1:0] cmt_id;
        logic [GRP_ID_W-1:0] grp_id;
        logic [BRTAG_W-1:0]  brtag;
        logic [VADDR_W-1:0]  pc_vaddr;
        logic                is_call;
        logic                is_ret;
        logic                is_rvc;
    } ftq_mp_enq_t;

    // Branch-unit resolution record
    typedef struct packed {
        logic [BRTAG_W-1:0] brtag;
        logic               is_cond;
        logic               taken;
        logic               mispredict;
        logic [VADDR_W-1:0] target_vaddr;
    } ftq_mp_upd_t;

    // Storage slot: control bits plus dispatch payload and captured resolution
    typedef struct packed {
        logic               valid;
        logic               done;
        logic               dead;
        ftq_mp_enq_t        info;
        logic               is_cond;
        logic               taken;
        logic               mispredict;
        logic [VADDR_W-1:0] target_vaddr;
    } ftq_mp_entry_t;

    // Record handed to the frontend; dead entries are retired but ignored there
    typedef struct packed {
        ftq_mp_enq_t        info;
        logic               is_cond;
        logic               taken;
        logic               mispredict;
        logic [VADDR_W-1:0] target_vaddr;
        logic               dead;
    } ftq_mp_deq_t;

endpackage

// File: rtl/msrh_ftq_mp_lane_pack.sv
// Packs sparse enqueue lanes: each valid lane gets the number of valid lanes
// below it as its slot offset from tail, plus the total count of valid lanes.
module msrh_ftq_mp_lane_pack #(
    parameter int ENQ_WIDTH = 2
) (
    input  logic [ENQ_WIDTH-1:0]                          i_valid,
    output logic [ENQ_WIDTH-1:0][$clog2(ENQ_WIDTH+1)-1:0] o_offset,
    output logic [$clog2(ENQ_WIDTH+1)-1:0]                o_count
);

    localparam int LCNT_W = $clog2(ENQ_WIDTH+1);

    // Exclusive prefix popcount over the lane valids
    always_comb begin
        logic [LCNT_W-1:0] acc;
        acc = '0;
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            o_offset[l] = acc;
            acc         = acc + LCNT_W'(i_valid[l]);
        end
        o_count = acc;
    end

endmodule

// File: rtl/msrh_ftq_mp.sv
// Multi-port fetch target queue: records dispatched branches, absorbs
// resolutions from several branch units, kills younger entries on a
// mispredict and retires entries in program order to the frontend.
module msrh_ftq_mp
    import msrh_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = 2,
    parameter int UPD_PORTS = 2
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [ENQ_WIDTH-1:0]              i_enq_valid,
    input  ftq_mp_enq_t [ENQ_WIDTH-1:0]       i_enq,
    output logic                              o_enq_ready,
    input  logic [UPD_PORTS-1:0]              i_upd_valid,
    input  ftq_mp_upd_t [UPD_PORTS-1:0]       i_upd,
    input  logic                              i_flush,
    output logic                              o_deq_valid,
    input  logic                              i_deq_ready,
    output ftq_mp_deq_t                       o_deq,
    output logic                              o_empty,
    output logic [$clog2(DEPTH+1)-1:0]        o_count
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int LCNT_W = $clog2(ENQ_WIDTH+1);

    ftq_mp_entry_t entries_q [DEPTH];
    ftq_mp_entry_t entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count;

    logic [ENQ_WIDTH-1:0][LCNT_W-1:0] lane_offset;
    logic [LCNT_W-1:0]                lane_count;
    logic                             enq_fire;
    logic                             deq_fire;
    ftq_mp_entry_t                    head_entry;

    msrh_ftq_mp_lane_pack #(
        .ENQ_WIDTH (ENQ_WIDTH)
    ) u_lane_pack (
        .i_valid  (i_enq_valid),
        .o_offset (lane_offset),
        .o_count  (lane_count)
    );

    // Pointer MSBs disambiguate full from empty, so the plain difference is the count
    assign count       = tail_q - head_q;
    assign o_count     = CNT_W'(count);
    assign o_empty     = (count == '0);
    assign o_enq_ready = (count <= PTR_W'(DEPTH - ENQ_WIDTH));
    assign head_entry  = entries_q[head_q[IDX_W-1:0]];
    assign o_deq_valid = head_entry.valid & head_entry.done;
    assign enq_fire    = (|i_enq_valid) & o_enq_ready;
    assign deq_fire    = o_deq_valid & i_deq_ready;

    // Head payload straight from registered storage
    always_comb begin
        o_deq              = '0;
        o_deq.info         = head_entry.info;
        o_deq.is_cond      = head_entry.is_cond;
        o_deq.taken        = head_entry.taken;
        o_deq.mispredict   = head_entry.mispredict;
        o_deq.target_vaddr = head_entry.target_vaddr;
        o_deq.dead         = head_entry.dead;
    end

    // Next state: resolution capture, age-based kill, dequeue, packed enqueue, flush
    always_comb begin
        logic [UPD_PORTS-1:0]            port_hit;
        logic [UPD_PORTS-1:0][IDX_W-1:0] port_age;
        logic                            kill_vld;
        logic [IDX_W-1:0]                kill_age;
        logic [IDX_W-1:0]                ent_age;
        logic [IDX_W-1:0]                slot;

        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        port_hit  = '0;
        port_age  = '0;
        kill_vld  = 1'b0;
        kill_age  = '1;
        ent_age   = '0;
        slot      = '0;

        // Locate each port's matching entry and its age relative to head
        for (int p = 0; p < UPD_PORTS; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_upd_valid[p] && entries_q[i].valid &&
                    entries_q[i].info.brtag == i_upd[p].brtag) begin
                    port_hit[p] = 1'b1;
                    port_age[p] = IDX_W'(i) - head_q[IDX_W-1:0];
                end
            end
        end

        // The oldest mispredicting branch sets the kill boundary
        for (int p = 0; p < UPD_PORTS; p++) begin
            if (port_hit[p] && i_upd[p].mispredict &&
                (!kill_vld || port_age[p] < kill_age)) begin
                kill_vld = 1'b1;
                kill_age = port_age[p];
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            ent_age = IDX_W'(i) - head_q[IDX_W-1:0];
            // Scan high to low so the lowest-index matching port lands last
            for (int p = UPD_PORTS - 1; p >= 0; p--) begin
                if (i_upd_valid[p] && entries_q[i].valid &&
                    entries_q[i].info.brtag == i_upd[p].brtag) begin
                    entries_d[i].done         = 1'b1;
                    entries_d[i].is_cond      = i_upd[p].is_cond;
                    entries_d[i].taken        = i_upd[p].taken;
                    entries_d[i].mispredict   = i_upd[p].mispredict;
                    entries_d[i].target_vaddr = i_upd[p].target_vaddr;
                end
            end
            if (kill_vld && entries_q[i].valid && ent_age > kill_age) begin
                entries_d[i].done = 1'b1;
                entries_d[i].dead = 1'b1;
            end
        end

        if (deq_fire) begin
            entries_d[head_q[IDX_W-1:0]].valid = 1'b0;
            head_d = head_q + PTR_W'(1);
        end

        // Same-cycle enqueues are younger than any resolving branch
        if (enq_fire) begin
            for (int l = 0; l < ENQ_WIDTH; l++) begin
                if (i_enq_valid[l]) begin
                    slot = tail_q[IDX_W-1:0] + IDX_W'(lane_offset[l]);
                    entries_d[slot] = '{valid:        1'b1,
                                        done:         kill_vld,
                                        dead:         kill_vld,
                                        info:         i_enq[l],
                                        is_cond:      1'b0,
                                        taken:        1'b0,
                                        mispredict:   1'b0,
                                        target_vaddr: '0};
                end
            end
            tail_d = tail_q + PTR_W'(lane_count);
        end

        if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    // State registers; reset only clears control so payload holds its last value
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_msrh_ftq_mp.sv
// Directed bench for msrh_ftq_mp with an in-order scoreboard of expected
// retirements that tracks resolution, kill and flush behaviour.
module tb_msrh_ftq_mp;
    import msrh_pkg::*;

    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        enq_valid;
    ftq_mp_enq_t [1:0] enq;
    logic              enq_ready;
    logic [1:0]        upd_valid;
    ftq_mp_upd_t [1:0] upd;
    logic              flush;
    logic              deq_valid;
    logic              deq_ready;
    ftq_mp_deq_t       deq;
    logic              empty;
    logic [4:0]        count;

    typedef struct packed {
        logic [3:0]  tag;
        logic        done;
        logic        dead;
        logic        mp;
        logic [38:0] tgt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    ftq_mp_upd_t nu;

    msrh_ftq_mp #(.DEPTH(16), .ENQ_WIDTH(2), .UPD_PORTS(2)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enq_valid (enq_valid),
        .i_enq       (enq),
        .o_enq_ready (enq_ready),
        .i_upd_valid (upd_valid),
        .i_upd       (upd),
        .i_flush     (flush),
        .o_deq_valid (deq_valid),
        .i_deq_ready (deq_ready),
        .o_deq       (deq),
        .o_empty     (empty),
        .o_count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic ftq_mp_enq_t mk_enq(input logic [3:0] tag);
        ftq_mp_enq_t e;
        e          = '0;
        e.cmt_id   = {2'b00, tag};
        e.grp_id   = 5'd1;
        e.brtag    = tag;
        e.pc_vaddr = 39'h10000 + {33'd0, tag, 2'b00};
        return e;
    endfunction

    function automatic ftq_mp_upd_t mk_upd(input logic [3:0] tag, input logic mp, input logic [38:0] tgt);
        ftq_mp_upd_t u;
        u              = '0;
        u.brtag        = tag;
        u.is_cond      = 1'b1;
        u.taken        = 1'b1;
        u.mispredict   = mp;
        u.target_vaddr = tgt;
        return u;
    endfunction

    task automatic state_checks();
        int n;
        n = exp_q.size();
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("enq_ready", 64'(enq_ready), 64'(n <= DEPTH - 2));
        chk("deq_valid", 64'(deq_valid), 64'(n > 0 && exp_q[0].done));
    endtask

    // One clock of stimulus; the scoreboard is advanced with the same cycle semantics
    task automatic cyc(input logic [1:0] ev, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [1:0] uv, input ftq_mp_upd_t u0, input ftq_mp_upd_t u1,
                       input logic dr, input logic fl);
        exp_t        e;
        ftq_mp_upd_t u;
        ftq_mp_enq_t pe;
        int          kill_idx;
        bit          ready;
        enq_valid = ev;
        enq[0]    = mk_enq(t0);
        enq[1]    = mk_enq(t1);
        upd_valid = uv;
        upd[0]    = u0;
        upd[1]    = u1;
        deq_ready = dr;
        flush     = fl;
        #1;
        state_checks();
        ready = (exp_q.size() <= DEPTH - 2);
        if (dr && exp_q.size() > 0 && exp_q[0].done) begin
            e  = exp_q.pop_front();
            pe = mk_enq(e.tag);
            chk("deq_tag", 64'(deq.info.brtag), 64'(e.tag));
            chk("deq_pc", 64'(deq.info.pc_vaddr), 64'(pe.pc_vaddr));
            chk("deq_dead", 64'(deq.dead), 64'(e.dead));
            chk("deq_mp", 64'(deq.mispredict), 64'(e.mp));
            chk("deq_tgt", 64'(deq.target_vaddr), 64'(e.tgt));
        end
        kill_idx = -1;
        for (int p = 1; p >= 0; p--) begin
            u = (p == 0) ? u0 : u1;
            if (uv[p]) begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    if (exp_q[j].tag == u.brtag) begin
                        exp_q[j].done = 1'b1;
                        exp_q[j].mp   = u.mispredict;
                        exp_q[j].tgt  = u.target_vaddr;
                        if (u.mispredict && (kill_idx < 0 || j < kill_idx)) kill_idx = j;
                    end
                end
            end
        end
        if (kill_idx >= 0) begin
            for (int j = kill_idx + 1; j < exp_q.size(); j++) begin
                exp_q[j].done = 1'b1;
                exp_q[j].dead = 1'b1;
            end
        end
        if (ev != 2'b00 && ready) begin
            if (ev[0]) exp_q.push_back('{tag: t0, done: kill_idx >= 0, dead: kill_idx >= 0, mp: 1'b0, tgt: '0});
            if (ev[1]) exp_q.push_back('{tag: t1, done: kill_idx >= 0, dead: kill_idx >= 0, mp: 1'b0, tgt: '0});
        end
        if (fl) exp_q.delete();
        @(posedge clk);
        #1;
        enq_valid = '0;
        upd_valid = '0;
        deq_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic idle();
        cyc(2'b00, 4'd0, 4'd0, 2'b00, nu, nu, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        state_checks();
    endtask

    initial begin
        nu        = '0;
        rst       = 1'b1;
        enq_valid = '0;
        enq       = '0;
        upd_valid = '0;
        upd       = '0;
        flush     = 1'b0;
        deq_ready = 1'b0;
        @(posedge clk);
        do_reset();

        // Two lanes, resolve tag 1 then tag 2
        cyc(2'b11, 4'd1, 4'd2, 2'b00, nu, nu, 1'b0, 1'b0);
        idle();
        cyc(2'b00, 4'd0, 4'd0, 2'b01, mk_upd(4'd1, 1'b0, 39'h8000_0100), nu, 1'b0, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b10, nu, mk_upd(4'd2, 1'b0, 39'h8000_0200), 1'b1, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b00, nu, nu, 1'b1, 1'b0);
        idle();

        // Sparse lane mask: lane 1 lands in the tail slot
        cyc(2'b10, 4'd0, 4'd3, 2'b00, nu, nu, 1'b0, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b01, mk_upd(4'd3, 1'b0, 39'h123), nu, 1'b0, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b00, nu, nu, 1'b1, 1'b0);

        // Fill to full, attempt an extra enqueue, resolve all, drain one per cycle
        for (int k = 0; k < 8; k++)
            cyc(2'b11, 4'(2*k), 4'(2*k+1), 2'b00, nu, nu, 1'b0, 1'b0);
        cyc(2'b11, 4'd0, 4'd1, 2'b00, nu, nu, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            cyc(2'b00, 4'd0, 4'd0, 2'b11, mk_upd(4'(2*k), 1'b0, 39'(k * 16 + 8)),
                mk_upd(4'(2*k+1), 1'b0, 39'(k * 16 + 12)), 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) idle_deq: cyc(2'b00, 4'd0, 4'd0, 2'b00, nu, nu, 1'b1, 1'b0);

        // Streaming enqueue/resolve/dequeue across several pointer wraps
        for (int k = 0; k < 40; k++)
            cyc(2'b01, 4'(k), 4'd0, (k > 0) ? 2'b01 : 2'b00,
                mk_upd(4'(k - 1), 1'b0, 39'(k * 4 + 39'h4000)), nu, 1'b1, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b01, mk_upd(4'd7, 1'b0, 39'h5555), nu, 1'b1, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b00, nu, nu, 1'b1, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b00, nu, nu, 1'b1, 1'b0);

        // Mispredicts on tags 6 (port 0) and 4 (port 1) while tag 7 enqueues
        cyc(2'b11, 4'd3, 4'd4, 2'b00, nu, nu, 1'b0, 1'b0);
        cyc(2'b11, 4'd5, 4'd6, 2'b00, nu, nu, 1'b0, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b01, mk_upd(4'd3, 1'b0, 39'h300), nu, 1'b0, 1'b0);
        cyc(2'b01, 4'd7, 4'd0, 2'b11, mk_upd(4'd6, 1'b1, 39'h600),
            mk_upd(4'd4, 1'b1, 39'h7_0000_0400), 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cyc(2'b00, 4'd0, 4'd0, 2'b00, nu, nu, 1'b1, 1'b0);

        // Absent tag is ignored; dual update of one tag keeps port 0
        cyc(2'b01, 4'd5, 4'd0, 2'b00, nu, nu, 1'b0, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b01, mk_upd(4'd9, 1'b1, 39'h999), nu, 1'b0, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b11, mk_upd(4'd5, 1'b0, 39'h0AAA),
            mk_upd(4'd5, 1'b1, 39'h0BBB), 1'b0, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b00, nu, nu, 1'b1, 1'b0);

        // Flush beats a same-cycle enqueue and update
        cyc(2'b11, 4'd1, 4'd2, 2'b00, nu, nu, 1'b0, 1'b0);
        cyc(2'b01, 4'd3, 4'd0, 2'b01, mk_upd(4'd1, 1'b0, 39'h111), nu, 1'b0, 1'b1);
        idle();

        // Reset mid-stream with a resolved head pending
        cyc(2'b11, 4'd4, 4'd5, 2'b00, nu, nu, 1'b0, 1'b0);
        cyc(2'b00, 4'd0, 4'd0, 2'b01, mk_upd(4'd4, 1'b0, 39'h444), nu, 1'b0, 1'b0);
        do_reset();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
